// File: rtl/hci_package.sv
// Shared types and constants for the HCI memory-side bank adapters.
// Test-and-set FSM encoding, default test-and-set pattern and a width helper.
package hci_package;

    typedef enum logic {
        TS_IDLE  = 1'b0,
        TS_WRITE = 1'b1
    } hci_ts_state_e;

    // Wide enough for any practical bank word; adapters slice the low DW bits.
    localparam logic [1023:0] HCI_TS_VALUE_DEFAULT = '1;

    // Port width for optional fields: a zero-width field still needs one bit.
    function automatic int unsigned hci_max1(input int unsigned w);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/hci_mem_resp_reg.sv
// Response pipeline register for a 1-cycle-latency bank: one r_valid pulse per
// granted request and the ID captured in the grant cycle.
module hci_mem_resp_reg #(
    parameter int unsigned IW = 20
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          valid_i,
    input  logic [IW-1:0] id_i,
    output logic          r_valid_o,
    output logic [IW-1:0] r_id_o
);

    logic          r_valid_d, r_valid_q;
    logic [IW-1:0] r_id_d, r_id_q;

    // The ID holds between responses; clear drops anything granted this cycle.
    always_comb begin
        r_valid_d = valid_i;
        r_id_d    = valid_i ? id_i : r_id_q;
        if (clear_i) begin
            r_valid_d = 1'b0;
            r_id_d    = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;

endmodule

// File: rtl/hci_mem_ts_bank_adapter.sv
// Memory-side stage between one interconnect target port and a single-port
// SRAM bank, with atomic test-and-set done as read then locked all-ones write.
module hci_mem_ts_bank_adapter
    import hci_package::*;
#(
    parameter int unsigned   AWM      = 12,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   BW       = 8,
    parameter int unsigned   UW       = 0,
    parameter int unsigned   IW       = 20,
    parameter logic [DW-1:0] TS_VALUE = HCI_TS_VALUE_DEFAULT[DW-1:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AWM-1:0]         add_i,
    input  logic                   wen_i,
    input  logic [DW/BW-1:0]       be_i,
    input  logic [DW-1:0]          data_i,
    input  logic [hci_max1(UW)-1:0] user_i,
    input  logic [IW-1:0]          id_i,
    input  logic                   ts_set_i,
    output logic                   r_valid_o,
    output logic [DW-1:0]          r_data_o,
    output logic [hci_max1(UW)-1:0] r_user_o,
    output logic [IW-1:0]          r_id_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AWM-1:0]         sram_add_o,
    output logic [UW+DW-1:0]       sram_wdata_o,
    output logic [DW/BW-1:0]       sram_be_o,
    input  logic [UW+DW-1:0]       sram_rdata_i,
    output logic                   ts_busy_o
);

    localparam int unsigned SW = UW + DW;

    hci_ts_state_e  state_d, state_q;
    logic [AWM-1:0] ts_add_d, ts_add_q;
    logic [SW-1:0]  wdata_pass;
    logic [SW-1:0]  ts_word;

    if (UW > 0) begin : gen_user
        assign wdata_pass = {user_i, data_i};
        assign ts_word    = {{UW{1'b0}}, TS_VALUE};
        assign r_user_o   = sram_rdata_i[SW-1:DW];
    end else begin : gen_no_user
        logic unused_user;
        assign unused_user = ^user_i;
        assign wdata_pass  = data_i;
        assign ts_word     = TS_VALUE;
        assign r_user_o    = '0;
    end

    assign r_data_o = sram_rdata_i[DW-1:0];

    // NOTE: every output and next-state signal gets a default before the case
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ts_add_d     = ts_add_q;
        gnt_o        = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_add_o   = add_i;
        sram_be_o    = be_i;
        sram_wdata_o = wdata_pass;

        unique case (state_q)
            TS_IDLE: begin
                gnt_o      = 1'b1;
                sram_req_o = req_i;
                sram_we_o  = ~wen_i;
                // Only a read qualified by ts_set starts the locked write phase.
                if (req_i && wen_i && ts_set_i) begin
                    state_d  = TS_WRITE;
                    ts_add_d = add_i;
                end
            end
            TS_WRITE: begin
                // A clear in this cycle abandons the write so memory keeps its value.
                sram_req_o   = ~clear_i;
                sram_we_o    = 1'b1;
                sram_add_o   = ts_add_q;
                sram_be_o    = '1;
                sram_wdata_o = ts_word;
                state_d      = TS_IDLE;
            end
        endcase

        if (clear_i) begin
            state_d = TS_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= TS_IDLE;
            ts_add_q <= '0;
        end else begin
            state_q  <= state_d;
            ts_add_q <= ts_add_d;
        end
    end

    assign ts_busy_o = (state_q == TS_WRITE);

    hci_mem_resp_reg #(
        .IW (IW)
    ) i_resp_reg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .valid_i   (req_i & gnt_o),
        .id_i      (id_i),
        .r_valid_o (r_valid_o),
        .r_id_o    (r_id_o)
    );

endmodule

// File: tb/tb_hci_mem_ts_bank_adapter.sv
// Scoreboarded bench for hci_mem_ts_bank_adapter: a behavioural bank and port
// model predicts grants and responses; a monitor checks each response cycle.
module tb_hci_mem_ts_bank_adapter;

    localparam int AWM = 12;
    localparam int DW  = 32;
    localparam int IW  = 20;
    localparam int NW  = 1 << AWM;
    localparam logic [DW-1:0] ONES = '1;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           clear_i = 1'b0;
    logic           req_i = 1'b0;
    logic           gnt_o;
    logic [AWM-1:0] add_i = '0;
    logic           wen_i = 1'b1;
    logic [3:0]     be_i = '0;
    logic [DW-1:0]  data_i = '0;
    logic [0:0]     user_i = '0;
    logic [IW-1:0]  id_i = '0;
    logic           ts_set_i = 1'b0;
    logic           r_valid_o;
    logic [DW-1:0]  r_data_o;
    logic [0:0]     r_user_o;
    logic [IW-1:0]  r_id_o;
    logic           sram_req_o;
    logic           sram_we_o;
    logic [AWM-1:0] sram_add_o;
    logic [DW-1:0]  sram_wdata_o;
    logic [3:0]     sram_be_o;
    logic [DW-1:0]  sram_rdata_i = '0;
    logic           ts_busy_o;

    always #5 clk_i = ~clk_i;

    hci_mem_ts_bank_adapter #(
        .AWM (AWM), .DW (DW), .BW (8), .UW (0), .IW (IW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .add_i        (add_i),
        .wen_i        (wen_i),
        .be_i         (be_i),
        .data_i       (data_i),
        .user_i       (user_i),
        .id_i         (id_i),
        .ts_set_i     (ts_set_i),
        .r_valid_o    (r_valid_o),
        .r_data_o     (r_data_o),
        .r_user_o     (r_user_o),
        .r_id_o       (r_id_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_add_o   (sram_add_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_be_o    (sram_be_o),
        .sram_rdata_i (sram_rdata_i),
        .ts_busy_o    (ts_busy_o)
    );

    // Environment: the physical bank the adapter drives.
    logic [DW-1:0] sram_mem [NW];
    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram_mem[sram_add_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_add_o];
            end
        end
    end

    // Reference model: memory contents as the port should observe them.
    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        bit            rd;
    } exp_t;

    logic [DW-1:0]  ref_mem [NW];
    exp_t           sb[$];
    bit             ts_stall = 1'b0;
    logic [AWM-1:0] ts_addr = '0;
    int             total = 0;
    int             bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) begin
        exp_t e;
        #3;
        if (rst_ni) begin
            if (r_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", 64'(r_valid_o), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("r_id", 64'(r_id_o), 64'(e.id));
                    if (e.rd) check("r_data", 64'(r_data_o), 64'(e.data));
                    check("r_user", 64'(r_user_o), 64'd0);
                end
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                check("missing_rvalid", 64'(r_valid_o), 64'd1);
            end
        end
    end

    // One port cycle: drive, predict grant, update model, advance to next cycle.
    task automatic step(input bit req, input bit rd, input bit ts, input logic [AWM-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be, input logic [IW-1:0] id,
                        input bit clr, output bit granted);
        bit   exp_gnt;
        bit   stall_next;
        exp_t e;
        req_i = req; wen_i = rd; ts_set_i = ts; add_i = a; data_i = d;
        be_i = be; id_i = id; clear_i = clr;
        exp_gnt    = !ts_stall;
        stall_next = 1'b0;
        if (ts_stall && !clr) ref_mem[ts_addr] = ONES;
        @(negedge clk_i);
        check("gnt", 64'(gnt_o), 64'(exp_gnt));
        check("ts_busy", 64'(ts_busy_o), 64'(!exp_gnt));
        granted = req && exp_gnt;
        if (granted) begin
            if (rd) begin
                e.data = ref_mem[a];
                if (ts && !clr) begin
                    stall_next = 1'b1;
                    ts_addr    = a;
                end
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                e.data = '0;
            end
            e.id = id;
            e.rd = rd;
            if (!clr) sb.push_back(e);
        end
        ts_stall = stall_next;
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input bit rd, input bit ts, input logic [AWM-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be, input logic [IW-1:0] id);
        bit g = 1'b0;
        for (int t = 0; t < 8 && !g; t++) step(1'b1, rd, ts, a, d, be, id, 1'b0, g);
        check("grant_timeout", 64'(g), 64'd1);
    endtask

    task automatic idle(input int n);
        bit g;
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0, g);
    endtask

    task automatic do_reset();
        req_i = 1'b0; ts_set_i = 1'b0; clear_i = 1'b0;
        rst_ni = 1'b0;
        sb.delete();
        ts_stall = 1'b0;
        #1;
        check("rst_r_valid", 64'(r_valid_o), 64'd0);
        check("rst_r_id", 64'(r_id_o), 64'd0);
        check("rst_ts_busy", 64'(ts_busy_o), 64'd0);
        check("rst_gnt", 64'(gnt_o), 64'd1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        logic [DW-1:0] v;
        for (int i = 0; i < NW; i++) begin
            v = $urandom;
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        sram_mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
        for (int i = 12'h020; i < 12'h070; i += 12'h010) begin
            sram_mem[i] = '0; ref_mem[i] = '0;
        end
        sram_mem[12'h032] = '0; ref_mem[12'h032] = '0;
        sram_mem[12'h050] = 32'd7; ref_mem[12'h050] = 32'd7;
        sram_mem[12'h060] = 32'd9; ref_mem[12'h060] = 32'd9;

        @(posedge clk_i);
        do_reset();

        issue(1'b1, 1'b0, 12'h010, '0, 4'hF, 20'd5);
        idle(1);

        issue(1'b0, 1'b0, 12'h020, 32'h12345678, 4'b0011, 20'd1);
        issue(1'b1, 1'b0, 12'h020, '0, 4'hF, 20'd2);
        idle(1);

        issue(1'b1, 1'b1, 12'h030, '0, 4'hF, 20'd3);
        idle(2);
        issue(1'b1, 1'b0, 12'h030, '0, 4'hF, 20'd4);
        idle(1);

        issue(1'b1, 1'b1, 12'h032, '0, 4'hF, 20'd6);
        issue(1'b1, 1'b0, 12'h032, '0, 4'hF, 20'd7);
        idle(1);

        issue(1'b0, 1'b1, 12'h040, 32'hAAAA5555, 4'hF, 20'd8);
        idle(1);
        issue(1'b1, 1'b0, 12'h040, '0, 4'hF, 20'd9);
        idle(1);

        issue(1'b1, 1'b1, 12'h050, '0, 4'hF, 20'd10);
        do_reset();
        issue(1'b1, 1'b0, 12'h050, '0, 4'hF, 20'd11);
        idle(1);

        issue(1'b1, 1'b1, 12'h060, '0, 4'hF, 20'h0ABCD);
        step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 1'b1, g);
        check("clr_r_id", 64'(r_id_o), 64'd0);
        check("clr_r_valid", 64'(r_valid_o), 64'd0);
        step(1'b1, 1'b1, 1'b0, 12'h010, '0, 4'hF, 20'd12, 1'b1, g);
        idle(1);
        issue(1'b1, 1'b0, 12'h060, '0, 4'hF, 20'd13);
        idle(1);

        for (int n = 0; n < 400; n++) begin
            bit rd;
            bit ts;
            rd = ($urandom_range(0, 1) == 1);
            ts = ($urandom_range(0, 3) == 0);
            issue(rd, ts, 12'h100 + 12'($urandom_range(0, 7)), $urandom,
                  4'($urandom), 20'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hci_mem_ts_bank_adapter.md
Name: hci_mem_ts_bank_adapter

Overview:
- Memory-side stage between one interconnect target port (req/gnt, add, wen, be, data, user, id, ts_set) and a single-port, 1-cycle-latency SRAM bank.
- Generates the bank response (r_valid, r_data, r_user, r_id).
- Executes test-and-set atomically as a read followed by a locked all-ones write, stalling the port for one cycle.
- One instance per bank, N_MEM instances per cluster.

Parameters:
- AWM, 12, bank word-address width.
- DW, 32, data width.
- BW, 8, byte width; byte-enable width is DW/BW.
- UW, 0, user width. UW=0 means no user field: r_user_o is tied 0 and SRAM is DW wide.
- IW, 20, request ID width.
- TS_VALUE, all-ones (DW bits), data written by the test-and-set second phase.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear, same effect as reset
- req_i  in  1  request valid
- gnt_o  out  1  request grant
- add_i  in  AWM  word address within bank
- wen_i  in  1  1=read, 0=write
- be_i  in  DW/BW  byte enables
- data_i  in  DW  write data
- user_i  in  max(UW,1)  write user bits
- id_i  in  IW  requester ID
- ts_set_i  in  1  test-and-set qualifier
- r_valid_o  out  1  response valid
- r_data_o  out  DW  read data
- r_user_o  out  max(UW,1)  read user bits
- r_id_o  out  IW  response ID
- sram_req_o  out  1  bank chip select
- sram_we_o  out  1  1=write
- sram_add_o  out  AWM  bank address
- sram_wdata_o  out  UW+DW  user and data concatenated, user in MSBs
- sram_be_o  out  DW/BW  byte enables
- sram_rdata_i  in  UW+DW  read data, valid 1 cycle after a read
- ts_busy_o  out  1  high while in TS_WRITE

Behaviour:
- Reset and clear values: state=IDLE; r_valid_o=0; r_id_o=0; ts_busy_o=0.
- r_data_o and r_user_o are driven combinationally from sram_rdata_i. They are meaningful only when r_valid_o=1 and the response is for a read.
- FSM states:
  - IDLE: gnt_o=1. sram_req_o=req_i; sram_we_o=~wen_i; add, be and wdata pass through.
  - TS_WRITE: gnt_o=0. sram_req_o=1; sram_we_o=1; sram_add_o=latched address; sram_be_o=all ones; sram_wdata_o={UW'0, TS_VALUE}.
- Transitions:
  - IDLE -> TS_WRITE when req_i & wen_i & ts_set_i. Address is latched in that cycle.
  - TS_WRITE -> IDLE unconditionally after 1 cycle.
  - ts_set_i with wen_i=0 is a plain write; no state change.
- Response timing:
  - Every granted request (req_i & gnt_o), read or write, yields exactly one r_valid_o pulse the next cycle.
  - r_id_o carries the ID registered in the grant cycle; it holds its value when no request is granted.
  - A test-and-set response carries the pre-write (old) data, because the SRAM read precedes the write.
- TS_WRITE internal write produces no response.
- Back-to-back granted requests give r_valid_o high on consecutive cycles. There is no internal buffering: the requester must accept responses unconditionally.
- A request held during TS_WRITE stays ungranted. It is granted in the following IDLE cycle and observes TS_VALUE.
- Reset or clear asserted in TS_WRITE:
  - State returns to IDLE and the pending TS write is dropped; memory keeps its old value.
  - No response is produced for any request granted in the cycle clear_i is sampled high.
- gnt_o is never high in TS_WRITE. ts_busy_o equals (state==TS_WRITE).
- Widths: all address and data paths pass through unresized; no arithmetic.

Decomposition:
- hci_package holds:
  - hci_ts_state_e enum {TS_IDLE, TS_WRITE};
  - constant HCI_TS_VALUE_DEFAULT.
- Single module. An optional sub-module, hci_mem_resp_reg, holds the r_valid/r_id pipeline register so it can be reused by non-atomic bank adapters.

Test Plan:
- Read 0x010 holding 0xDEADBEEF, id=5 -> gnt same cycle; next cycle r_valid_o=1, r_data_o=0xDEADBEEF, r_id_o=5.
- Write 0x020 with data 0x12345678, be=4'b0011, then read 0x020 (memory previously 0) -> first r_valid 1 cycle after write; read returns 0x00005678.
- Test-and-set read 0x030 (mem=0), id=3 -> r_data_o=0 with r_id_o=3; ts_busy_o=1 for 1 cycle; gnt_o=0 in that cycle; a later read of 0x030 returns 0xFFFFFFFF.
- Test-and-set, then a plain read of 0x030 held with req_i=1 -> read not granted during TS_WRITE, granted next cycle, returns 0xFFFFFFFF.
- Write with ts_set_i=1 of 0xAAAA5555 to 0x040 -> no stall, ts_busy_o stays 0, reading 0x040 returns 0xAAAA5555.
- Assert rst_ni=0 during TS_WRITE on 0x050 (mem=7) -> state IDLE, r_valid_o=0, 0x050 still reads 7 after reset release.
